mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller directly downstream of the store/load buffer and the fetcher.
- Arbitrates instruction-fetch reads and load/store accesses onto the single 8-bit RAM port.
- Assembles or splits 32-bit words and returns completion pulses to the requesters.
- Sole owner of mem_a/mem_dout/mem_wr.

Parameters:
- AddrWidth, 32, width of every address bus.
- DataWidth, 32, width of word data buses.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; when 0, all state holds and mem_wr is forced to 0.
- clear  in  1  pipeline flush (mispredict/exception).
- mem_din  in  8  RAM read byte; valid one cycle after its address.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  RAM write strobe (1 = write).
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  32  fetch address, word-aligned.
- if_ready  out  1  one-cycle pulse: if_data valid.
- if_data  out  32  fetched instruction, little-endian.
- ls_req  in  1  load/store request, held until ls_ready.
- ls_store  in  1  1 = store, 0 = load.
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- ls_addr  in  32  access address; no alignment required.
- ls_wdata  in  32  store data; low N bytes are used.
- ls_ready  out  1  one-cycle pulse: load data valid / store done.
- ls_rdata  out  32  load data, zero-extended; sign extension is done by the requester.

Behaviour:
- Reset (rst=0, asynchronous): state = IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_ready=0, ls_ready=0, if_data=0, ls_rdata=0; byte counter = 0. Reset mid-access abandons the access.
- All outputs are registered. Every transition below requires rdy_in=1.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If ls_req=1, latch ls_* and go to READ or WRITE (ls_store selects). ls_req has priority over if_req.
  - Otherwise, if if_req=1 and clear=0, latch if_addr with N=4 and go to READ.
  - No preemption once an access has started.
- READ (N bytes, counter k):
  - Drive mem_a = base+k for k = 0..N-1 on consecutive cycles.
  - Capture mem_din into byte k one cycle after mem_a = base+k.
  - After byte N-1 is captured, pulse the owner's ready for exactly one cycle with data, then go to DONE.
  - Total latency: accept edge to ready = N+1 cycles.
- WRITE:
  - Drive mem_a = base+k, mem_dout = wdata[8k+7:8k], mem_wr=1 for k = 0..N-1.
  - The cycle after the last byte: mem_wr=0, ls_ready pulses, go to DONE.
- DONE: one idle cycle with no accept, so the requester can drop its req. Then go to IDLE.
- Address arithmetic: base+k wraps modulo 2^32.
- clear:
  - During a fetch READ: abort at the next edge to IDLE, mem_wr=0, no if_ready.
  - During a load: abort the same way, no ls_ready.
  - During a store: no effect. A store reaching the controller is already committed, so it completes and ls_ready pulses.
  - clear=1 in IDLE blocks fetch acceptance but not ls acceptance.
- Simultaneous clear and a final byte: clear wins for fetches and loads; no ready pulse.
- rdy_in=0 mid-access freezes the counter and mem_a. The byte pending on mem_din is recaptured once rdy_in returns; the RAM holds its output while the address is stable.
- mem_wr=1 only ever in WRITE.

Optional Feature:
- Macro: IO_BUFFER_FULL_EN.
- Defined: adds input io_buffer_full (1 bit).
  - A store with ls_addr[17:16]=2'b11 (UART region) is not accepted in IDLE while io_buffer_full=1.
  - Any write byte to that region waits in WRITE with mem_wr=0 while io_buffer_full=1.
  - Additionally, every IO-region store is followed by one forced mem_wr=0 cycle before the next byte or the ready pulse.
- Undefined: the port is absent and IO stores behave like ordinary stores.

Test Plan:
- Fetch: if_req=1, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 → mem_a 0x100..0x103 on consecutive cycles; if_ready pulses once at cycle 5 with if_data=0x00100513.
- Store: ls_req, ls_store=1, size=1, addr=0x2001, wdata=0xDEADBEEF → writes 0xEF to 0x2001 and 0xBE to 0x2002 with mem_wr=1; ls_ready one cycle later; no other mem_wr pulses.
- Contention: if_req and ls_req (load, size=0, addr=0x3, byte 0x80) asserted together → load serviced first with ls_rdata=0x00000080; then DONE, IDLE, and the fetch starts.
- clear during a fetch after 2 bytes → no if_ready, back to IDLE. clear during a store → store completes and ls_ready pulses.
- Reset (rst=0) mid-WRITE → mem_wr falls immediately (asynchronously). After release the FSM is IDLE and a new fetch completes normally.
- With IO_BUFFER_FULL_EN: byte store to 0x30000 while io_buffer_full=1 → no mem_wr. After io_buffer_full drops, one write of the byte, then ls_ready.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating fetch and load/store
// onto one 8-bit port; assembles/splits 32-bit words.
// Ports: clk, rst (async active-low), rdy_in (global enable), clear (flush),
//   mem_din/mem_dout/mem_a/mem_wr (RAM port), if_* (fetch), ls_* (load/store).
// Optional macro IO_BUFFER_FULL_EN adds io_buffer_full back-pressure for
//   stores to the UART region (addr[17:16] == 2'b11).
module mem_ctrl #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_in,
    input  logic                 clear,
`ifdef IO_BUFFER_FULL_EN
    input  logic                 io_buffer_full,
`endif
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [AddrWidth-1:0] mem_a,
    output logic                 mem_wr,
    input  logic                 if_req,
    input  logic [AddrWidth-1:0] if_addr,
    output logic                 if_ready,
    output logic [DataWidth-1:0] if_data,
    input  logic                 ls_req,
    input  logic                 ls_store,
    input  logic [1:0]           ls_size,
    input  logic [AddrWidth-1:0] ls_addr,
    input  logic [DataWidth-1:0] ls_wdata,
    output logic                 ls_ready,
    output logic [DataWidth-1:0] ls_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2:0]           len_q, len_d;
    logic                 fetch_q, fetch_d;
    logic [AddrWidth-1:0] base_q, base_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] buf_q, buf_d;
    logic [AddrWidth-1:0] mem_a_q, mem_a_d;
    logic [7:0]           mem_dout_q, mem_dout_d;
    logic                 mem_wr_q, mem_wr_d;
    logic                 if_ready_q, if_ready_d;
    logic                 ls_ready_q, ls_ready_d;
    logic [DataWidth-1:0] if_data_q, if_data_d;
    logic [DataWidth-1:0] ls_rdata_q, ls_rdata_d;

    logic                 io_region, io_hold, ls_block;
    logic [AddrWidth-1:0] nxt_a;
    logic [1:0]           cap_idx, nxt_idx;
    logic [DataWidth-1:0] asm_word;

`ifdef IO_BUFFER_FULL_EN
    assign io_region = (mem_a_q[17:16] == 2'b11);
    assign io_hold   = io_region && io_buffer_full;
    assign ls_block  = ls_store && (ls_addr[17:16] == 2'b11) && io_buffer_full;
`else
    assign io_region = 1'b0;
    assign io_hold   = 1'b0;
    assign ls_block  = 1'b0;
`endif

    assign nxt_a   = base_q + AddrWidth'(cnt_q) + AddrWidth'(1);
    assign cap_idx = 2'(cnt_q - 3'd1);
    assign nxt_idx = 2'(cnt_q + 3'd1);

    // mem_din carries the byte addressed on the previous edge (index cnt-1)
    always_comb begin
        asm_word = buf_q;
        asm_word[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        fetch_d    = fetch_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_ready_d = if_ready_q;
        ls_ready_d = ls_ready_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if (rdy_in) begin
            if_ready_d = 1'b0;
            ls_ready_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ls_req) begin
                        if (!ls_block) begin
                            base_d  = ls_addr;
                            mem_a_d = ls_addr;
                            cnt_d   = 3'd0;
                            fetch_d = 1'b0;
                            wdata_d = ls_wdata;
                            buf_d   = '0;
                            case (ls_size)
                                2'd0:    len_d = 3'd1;
                                2'd1:    len_d = 3'd2;
                                default: len_d = 3'd4;
                            endcase
                            if (ls_store) begin
                                mem_dout_d = ls_wdata[7:0];
                                mem_wr_d   = 1'b1;
                                state_d    = WRITE;
                            end else begin
                                state_d = READ;
                            end
                        end
                    end else if (if_req && !clear) begin
                        base_d  = if_addr;
                        mem_a_d = if_addr;
                        cnt_d   = 3'd0;
                        len_d   = 3'd4;
                        fetch_d = 1'b1;
                        buf_d   = '0;
                        state_d = READ;
                    end
                end
                READ: begin
                    if (clear) begin
                        state_d = IDLE;
                    end else if (cnt_q == len_q) begin
                        state_d = DONE;
                        if (fetch_q) begin
                            if_ready_d = 1'b1;
                            if_data_d  = asm_word;
                        end else begin
                            ls_ready_d = 1'b1;
                            ls_rdata_d = asm_word;
                        end
                    end else begin
                        if (cnt_q != 3'd0) buf_d = asm_word;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q + 3'd1 < len_q) mem_a_d = nxt_a;
                    end
                end
                WRITE: begin
                    // a held IO byte stays on the bus; an IO byte just
                    // written is followed by one mem_wr=0 gap cycle
                    if (!(mem_wr_q && io_hold)) begin
                        if (mem_wr_q && io_region) begin
                            mem_wr_d = 1'b0;
                        end else if (cnt_q == len_q - 3'd1) begin
                            mem_wr_d   = 1'b0;
                            ls_ready_d = 1'b1;
                            state_d    = DONE;
                        end else begin
                            cnt_d      = cnt_q + 3'd1;
                            mem_a_d    = nxt_a;
                            mem_dout_d = wdata_q[{nxt_idx, 3'b000} +: 8];
                            mem_wr_d   = 1'b1;
                        end
                    end
                end
                DONE: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            fetch_q    <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            fetch_q    <= fetch_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_ready_q <= if_ready_d;
            ls_ready_q <= ls_ready_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q && rdy_in && !io_hold;
    assign if_ready = if_ready_q;
    assign if_data  = if_data_q;
    assign ls_ready = ls_ready_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte RAM model.
// Expected writes/reads are queued when stimulus is driven.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy_in, clear;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_ready;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_store, ls_ready;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
`ifdef IO_BUFFER_FULL_EN
    logic        io_buffer_full;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [39:0] exp_wr[$];
    logic [31:0] exp_if[$];
    logic [32:0] exp_ls[$];
    logic [7:0]  init_mem[logic [31:0]];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .clear(clear),
`ifdef IO_BUFFER_FULL_EN
        .io_buffer_full(io_buffer_full),
`endif
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_data(if_data), .ls_req(ls_req),
        .ls_store(ls_store), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (init_mem.exists(a)) return init_mem[a];
        return pat(a);
    endfunction

    // synchronous RAM: output holds while the controller is stalled
    always @(posedge clk)
        if (rdy_in) mem_din <= rd(mem_a);

    // scoreboard monitor
    always @(negedge clk) begin
        logic [39:0] ew;
        logic [31:0] ei;
        logic [32:0] el;
        if (rst) begin
            if (mem_wr) begin
                cmp_cnt++;
                if (exp_wr.size() == 0) begin
                    err_cnt++;
                    $display("FAIL wr_unexpected: got a=%h d=%h, want none",
                             mem_a, mem_dout);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({mem_a, mem_dout} !== ew) begin
                        err_cnt++;
                        $display("FAIL wr_data: got %h want %h",
                                 {mem_a, mem_dout}, ew);
                    end
                end
            end
            if (if_ready) begin
                cmp_cnt++;
                if (exp_if.size() == 0) begin
                    err_cnt++;
                    $display("FAIL if_unexpected: got %h, want none", if_data);
                end else begin
                    ei = exp_if.pop_front();
                    if (if_data !== ei) begin
                        err_cnt++;
                        $display("FAIL if_data: got %h want %h", if_data, ei);
                    end
                end
            end
            if (ls_ready) begin
                cmp_cnt++;
                if (exp_ls.size() == 0) begin
                    err_cnt++;
                    $display("FAIL ls_unexpected: got %h, want none", ls_rdata);
                end else begin
                    el = exp_ls.pop_front();
                    if (el[32] && ls_rdata !== el[31:0]) begin
                        err_cnt++;
                        $display("FAIL ls_rdata: got %h want %h",
                                 ls_rdata, el[31:0]);
                    end
                end
            end
        end
    end

    task automatic wait_if(input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!if_ready && n < bound);
    endtask

    task automatic wait_ls(input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ls_ready && n < bound);
    endtask

    task automatic if_run(input logic [31:0] a, output int n);
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = a;
        wait_if(20, n);
        if_req = 1'b0;
    endtask

    task automatic ls_run(input logic st, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int n);
        @(posedge clk); #1;
        ls_req   = 1'b1;
        ls_store = st;
        ls_size  = sz;
        ls_addr  = a;
        ls_wdata = wd;
        wait_ls(20, n);
        ls_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got[7];
        rst = 1'b0; rdy_in = 1'b1; clear = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_store = 1'b0; ls_size = '0;
        ls_addr = '0; ls_wdata = '0;
`ifdef IO_BUFFER_FULL_EN
        io_buffer_full = 1'b0;
`endif
        #12;
        got = '{mem_a, 32'(mem_dout), 32'(mem_wr), 32'(if_ready),
                32'(ls_ready), if_data, ls_rdata};
        for (int i = 0; i < 7; i++) begin
            cmp_cnt++;
            if (got[i] !== 32'd0) begin
                err_cnt++;
                $display("FAIL reset_out%0d: got %h want 0", i, got[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        @(posedge clk); #1;
        exp_if.push_back(32'h00100513);
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmp_cnt++;
            if (mem_a !== 32'h100 + 32'(k) || if_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL fetch_addr%0d: got a=%h rdy=%b want a=%h rdy=0",
                         k, mem_a, if_ready, 32'h100 + 32'(k));
            end
        end
        @(negedge clk);
        cmp_cnt++;
        if (if_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL fetch_early: got if_ready=%b want 0", if_ready);
        end
        @(negedge clk);
        cmp_cnt++;
        if (if_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL fetch_lat: got if_ready=%b want 1 at cycle 5",
                     if_ready);
        end
        if_req = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (if_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL fetch_pulse: got if_ready=%b want 0", if_ready);
        end
    endtask

    task automatic test_store();
        int n;
        exp_wr.push_back({32'h2001, 8'hef});
        exp_wr.push_back({32'h2002, 8'hbe});
        exp_ls.push_back({1'b0, 32'h0});
        ls_run(1'b1, 2'd1, 32'h2001, 32'hdeadbeef, n);
        cmp_cnt++;
        if (n - 1 != 2) begin
            err_cnt++;
            $display("FAIL store_lat: got %0d want 2", n - 1);
        end
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (exp_wr.size() != 0) begin
            err_cnt++;
            $display("FAIL store_left: got %0d pending want 0", exp_wr.size());
        end
    endtask

    task automatic test_load();
        int n;
        logic [31:0] wexp;
        logic [1:0]  sz[4]  = '{2'd0, 2'd1, 2'd3, 2'd2};
        logic [31:0] ad[4]  = '{32'h3, 32'h1001, 32'h2003, 32'hfffffffe};
        int          lat[4] = '{2, 3, 5, 5};
        logic [31:0] dv[4];
        wexp = {pat(32'h1), pat(32'h0), pat(32'hffffffff), pat(32'hfffffffe)};
        dv = '{32'h80, 32'h1234, 32'h44332211, wexp};
        for (int i = 0; i < 4; i++) begin
            exp_ls.push_back({1'b1, dv[i]});
            ls_run(1'b0, sz[i], ad[i], 32'h0, n);
            cmp_cnt++;
            if (n - 1 != lat[i]) begin
                err_cnt++;
                $display("FAIL load_lat%0d: got %0d want %0d",
                         i, n - 1, lat[i]);
            end
        end
    endtask

    task automatic test_contention();
        int n;
        @(posedge clk); #1;
        exp_ls.push_back({1'b1, 32'h80});
        exp_if.push_back(32'h00100513);
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_store = 1'b0; ls_size = 2'd0; ls_addr = 32'h3;
        wait_ls(20, n);
        ls_req = 1'b0;
        cmp_cnt++;
        if (n - 1 != 2 || if_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL cont_ls: got lat=%0d if_ready=%b want 2 0",
                     n - 1, if_ready);
        end
        @(negedge clk);
        cmp_cnt++;
        if (mem_a !== 32'h3) begin
            err_cnt++;
            $display("FAIL cont_done: got a=%h want 00000003", mem_a);
        end
        @(negedge clk);
        cmp_cnt++;
        if (mem_a !== 32'h100) begin
            err_cnt++;
            $display("FAIL cont_start: got a=%h want 00000100", mem_a);
        end
        wait_if(20, n);
        if_req = 1'b0;
        cmp_cnt++;
        if (n != 5) begin
            err_cnt++;
            $display("FAIL cont_if_lat: got %0d want 5", n);
        end
    endtask

    task automatic test_clear();
        int n, pulses;
        logic [31:0] a0;
        // fetch aborted after two bytes
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h200;
        @(posedge clk);
        @(posedge clk); #1;
        clear = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (if_ready || mem_wr) pulses++;
        end
        cmp_cnt++;
        if (pulses != 0) begin
            err_cnt++;
            $display("FAIL clr_fetch: got %0d pulses want 0", pulses);
        end
        exp_if.push_back(32'h00100513);
        if_run(32'h100, n);
        cmp_cnt++;
        if (n != 6) begin
            err_cnt++;
            $display("FAIL clr_refetch: got %0d want 6", n);
        end
        // load aborted after two bytes
        @(posedge clk); #1;
        ls_req = 1'b1; ls_store = 1'b0; ls_size = 2'd2; ls_addr = 32'h2003;
        @(posedge clk);
        @(posedge clk); #1;
        clear = 1'b1; ls_req = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (ls_ready) pulses++;
        end
        cmp_cnt++;
        if (pulses != 0) begin
            err_cnt++;
            $display("FAIL clr_load: got %0d pulses want 0", pulses);
        end
        // store with clear held throughout still completes
        clear = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] wd;
            wd = 32'h11223344;
            exp_wr.push_back({32'h4000 + 32'(k), wd[8*k +: 8]});
        end
        exp_ls.push_back({1'b0, 32'h0});
        ls_run(1'b1, 2'd2, 32'h4000, 32'h11223344, n);
        cmp_cnt++;
        if (n - 1 != 4) begin
            err_cnt++;
            $display("FAIL clr_store: got lat %0d want 4", n - 1);
        end
        // clear in IDLE blocks a fetch
        @(posedge clk); #1;
        a0 = mem_a;
        if_req = 1'b1; if_addr = 32'h100;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (if_ready || mem_a !== a0) pulses++;
        end
        cmp_cnt++;
        if (pulses != 0) begin
            err_cnt++;
            $display("FAIL clr_idle: got %0d changes want 0", pulses);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        exp_if.push_back(32'h00100513);
        wait_if(20, n);
        if_req = 1'b0;
        cmp_cnt++;
        if (n != 6) begin
            err_cnt++;
            $display("FAIL clr_idle_fetch: got %0d want 6", n);
        end
    endtask

    task automatic test_stall();
        int n;
        exp_if.push_back(32'h00100513);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk);
        @(posedge clk); #1;
        rdy_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cmp_cnt++;
            if (mem_a !== 32'h101 || if_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL stall_hold: got a=%h rdy=%b want 00000101 0",
                         mem_a, if_ready);
            end
        end
        @(posedge clk); #1;
        rdy_in = 1'b1;
        wait_if(20, n);
        if_req = 1'b0;
        cmp_cnt++;
        if (n != 4) begin
            err_cnt++;
            $display("FAIL stall_fetch: got %0d want 4", n);
        end
        exp_wr.push_back({32'h5000, 8'h77});
        exp_ls.push_back({1'b0, 32'h0});
        @(posedge clk); #1;
        ls_req = 1'b1; ls_store = 1'b1; ls_size = 2'd0;
        ls_addr = 32'h5000; ls_wdata = 32'h77;
        @(posedge clk); #1;
        rdy_in = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (mem_wr !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_wr: got mem_wr=%b want 0", mem_wr);
        end
        @(posedge clk); #1;
        rdy_in = 1'b1;
        wait_ls(20, n);
        ls_req = 1'b0;
        cmp_cnt++;
        if (n != 1) begin
            err_cnt++;
            $display("FAIL stall_store: got %0d want 1", n);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        exp_wr.push_back({32'h6000, 8'h0d});
        @(posedge clk); #1;
        ls_req = 1'b1; ls_store = 1'b1; ls_size = 2'd2;
        ls_addr = 32'h6000; ls_wdata = 32'hcafef00d;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0; ls_req = 1'b0;
        #1;
        cmp_cnt++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin
            err_cnt++;
            $display("FAIL rst_async: got wr=%b a=%h want 0 0", mem_wr, mem_a);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_if.push_back(32'h00100513);
        if_run(32'h100, n);
        cmp_cnt++;
        if (n != 6) begin
            err_cnt++;
            $display("FAIL rst_refetch: got %0d want 6", n);
        end
    endtask

`ifdef IO_BUFFER_FULL_EN
    task automatic test_io_full();
        int n, wr_seen;
        exp_wr.push_back({32'h30000, 8'ha5});
        exp_ls.push_back({1'b0, 32'h0});
        io_buffer_full = 1'b1;
        @(posedge clk); #1;
        ls_req = 1'b1; ls_store = 1'b1; ls_size = 2'd0;
        ls_addr = 32'h30000; ls_wdata = 32'ha5;
        wr_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_wr || ls_ready) wr_seen++;
        end
        cmp_cnt++;
        if (wr_seen != 0) begin
            err_cnt++;
            $display("FAIL io_block: got %0d events want 0", wr_seen);
        end
        @(posedge clk); #1;
        io_buffer_full = 1'b0;
        wait_ls(20, n);
        ls_req = 1'b0;
        cmp_cnt++;
        if (n != 3) begin
            err_cnt++;
            $display("FAIL io_lat: got %0d want 3", n);
        end
    endtask
`endif

    initial begin
        init_mem[32'h100] = 8'h13; init_mem[32'h101] = 8'h05;
        init_mem[32'h102] = 8'h10; init_mem[32'h103] = 8'h00;
        init_mem[32'h3]    = 8'h80;
        init_mem[32'h1001] = 8'h34; init_mem[32'h1002] = 8'h12;
        init_mem[32'h2003] = 8'h11; init_mem[32'h2004] = 8'h22;
        init_mem[32'h2005] = 8'h33; init_mem[32'h2006] = 8'h44;
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_contention();
        test_clear();
        test_stall();
        test_reset_mid_write();
`ifdef IO_BUFFER_FULL_EN
        test_io_full();
`endif
        repeat (4) @(negedge clk);
        cmp_cnt++;
        if (exp_wr.size() + exp_if.size() + exp_ls.size() != 0) begin
            err_cnt++;
            $display("FAIL drain: got %0d/%0d/%0d pending want 0/0/0",
                     exp_wr.size(), exp_if.size(), exp_ls.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, err_cnt);
        $finish;
    end

endmodule
